// File: rtl/sram_march_bist_pkg.sv
// rtl/sram_march_bist_pkg.sv - shared types, element indices and pattern select for the March C- BIST
package sram_march_bist_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_E0_W0,
    S_E1_R0W1_UP,
    S_E2_R1W0_UP,
    S_E3_R0W1_DN,
    S_E4_R1W0_DN,
    S_E5_R0_ALL,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;

  // Op encoding matches the active-low web0 pin directly.
  localparam logic OP_RD = 1'b1;
  localparam logic OP_WR = 1'b0;

  // 1 selects ~BG, 0 selects BG, for the read expectation or the write data of an element.
  function automatic logic pattern_inv(input logic [2:0] elem, input logic is_wr);
    if (is_wr) return (elem == E1) || (elem == E3);
    return (elem == E2) || (elem == E4);
  endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// rtl/sram_bist_cmp.sv - read-data compare stage, saturating error counter and first-fail capture
module sram_bist_cmp
  import sram_march_bist_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] exp,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        elem,
  input  logic [DATA_W-1:0] dout0,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic              clean
);

  logic              v_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        elem_q;
  logic              miss;

  // The tag is registered the edge the macro samples the read, so it lines up with dout0.
  assign miss  = v_q && (dout0 != exp_q);
  assign clean = (err_cnt == 8'd0) && !miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q       <= 1'b0;
      exp_q     <= '0;
      addr_q    <= '0;
      elem_q    <= '0;
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else if (clear) begin
      v_q       <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else begin
      v_q    <= rd_valid;
      exp_q  <= exp;
      addr_q <= addr;
      elem_q <= elem;
      if (miss) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        if (err_cnt == 8'd0) begin
          fail_addr <= addr_q;
          fail_elem <= elem_q;
          fail_data <= dout0;
        end
      end
    end
  end

endmodule

// File: rtl/sram_march_bist.sv
// rtl/sram_march_bist.sv - March C- BIST controller driving a single-port SRAM macro
module sram_march_bist
  import sram_march_bist_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int DEPTH = 512,
  parameter logic [DATA_W-1:0] BG = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic              csb0,
  output logic              web0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] dout0
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              phase;
  logic              rd_valid_q;
  logic [DATA_W-1:0] exp_q;
  logic [2:0]        elem_q;
  logic [2:0]        elem;
  logic              two_op, desc, is_wr, step, accept, clean;
  logic [ADDR_W-1:0] op_addr;

  always_comb begin
    elem   = E0;
    two_op = 1'b0;
    desc   = 1'b0;
    case (state)
      S_E1_R0W1_UP: begin elem = E1; two_op = 1'b1; end
      S_E2_R1W0_UP: begin elem = E2; two_op = 1'b1; end
      S_E3_R0W1_DN: begin elem = E3; two_op = 1'b1; desc = 1'b1; end
      S_E4_R1W0_DN: begin elem = E4; two_op = 1'b1; desc = 1'b1; end
      S_E5_R0_ALL:  elem = E5;
      default:      elem = E0;
    endcase
    // cnt always counts up; descending elements mirror it onto the address.
    is_wr   = (state == S_E0_W0) || (two_op && phase);
    step    = !two_op || phase;
    op_addr = desc ? (LAST - cnt) : cnt;
  end

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      phase      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      csb0       <= 1'b1;
      web0       <= 1'b1;
      addr0      <= '0;
      din0       <= '0;
      rd_valid_q <= 1'b0;
      exp_q      <= '0;
      elem_q     <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      if (accept) begin
        state <= S_E0_W0;
        cnt   <= '0;
        phase <= 1'b0;
        busy  <= 1'b1;
        done  <= 1'b0;
        pass  <= 1'b0;
        csb0  <= 1'b1;
        web0  <= 1'b1;
      end else begin
        case (state)
          S_E0_W0, S_E1_R0W1_UP, S_E2_R1W0_UP, S_E3_R0W1_DN, S_E4_R1W0_DN, S_E5_R0_ALL: begin
            csb0       <= 1'b0;
            web0       <= is_wr ? OP_WR : OP_RD;
            addr0      <= op_addr;
            din0       <= BG ^ {DATA_W{pattern_inv(elem, 1'b1)}};
            rd_valid_q <= !is_wr;
            exp_q      <= BG ^ {DATA_W{pattern_inv(elem, 1'b0)}};
            elem_q     <= elem;
            if (step) begin
              cnt   <= cnt + 1'b1;
              phase <= 1'b0;
              if (cnt == LAST) state <= state_t'(state + 4'd1);
            end else begin
              phase <= 1'b1;
            end
          end
          S_FLUSH: begin
            csb0  <= 1'b1;
            web0  <= 1'b1;
            state <= S_DONE;
          end
          S_DONE: begin
            // Entered one edge early so pass can include the final E5 compare.
            done <= 1'b1;
            busy <= 1'b0;
            pass <= clean;
          end
          default: begin
            csb0 <= 1'b1;
            web0 <= 1'b1;
          end
        endcase
      end
    end
  end

  sram_bist_cmp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .rd_valid (rd_valid_q),
    .exp      (exp_q),
    .addr     (addr0),
    .elem     (elem_q),
    .dout0    (dout0),
    .err_cnt  (err_cnt),
    .fail_addr(fail_addr),
    .fail_elem(fail_elem),
    .fail_data(fail_data),
    .clean    (clean)
  );

endmodule

// File: tb/tb_sram_march_bist.sv
// tb/tb_sram_march_bist.sv - self-checking bench for sram_march_bist with behavioural SRAM models
module tb_sram_march_bist;

  localparam int DEPTH = 512;
  localparam int NOPS  = 5120;
  localparam logic [7:0] BG_B = 8'h5A;

  typedef struct packed {
    logic       wr;
    logic [8:0] addr;
    logic [7:0] din;
  } op_t;

  typedef struct {
    logic       pass;
    logic [7:0] err;
    logic [8:0] fa;
    logic [2:0] fe;
    logic [7:0] fd;
  } res_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start_b = 1'b0;
  logic busy, done, pass, csb0, web0;
  logic [7:0] err_cnt, fail_data, din0, dout0;
  logic [8:0] fail_addr, addr0;
  logic [2:0] fail_elem;
  logic busy_b, done_b, pass_b, csb0_b, web0_b;
  logic [7:0] err_cnt_b, fail_data_b, din0_b, dout0_b;
  logic [8:0] fail_addr_b, addr0_b;
  logic [2:0] fail_elem_b;

  int checks = 0, errors = 0, cyc = 0;
  res_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_march_bist dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  sram_march_bist #(.BG(BG_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_cnt_b), .fail_addr(fail_addr_b), .fail_elem(fail_elem_b), .fail_data(fail_data_b),
    .csb0(csb0_b), .web0(web0_b), .addr0(addr0_b), .din0(din0_b), .dout0(dout0_b)
  );

  // SRAM models: synchronous write, read data valid the cycle after the read.
  logic [7:0] mem_a [DEPTH];
  logic [7:0] mem_b [DEPTH];
  logic [8:0] stuck_addr = '0;
  logic [7:0] stuck_mask = '0;
  logic       all_ff = 1'b0;

  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) mem_a[addr0] <= din0;
      else dout0 <= all_ff ? 8'hFF : (mem_a[addr0] | ((addr0 == stuck_addr) ? stuck_mask : 8'h00));
    end
    if (!csb0_b) begin
      if (!web0_b) mem_b[addr0_b] <= din0_b;
      else dout0_b <= mem_b[addr0_b];
    end
  end

  function automatic op_t exp_op(input int k, input logic [7:0] bg);
    op_t o;
    int j, e, w;
    o.wr = 1'b0; o.addr = '0; o.din = bg;
    if (k < DEPTH) begin
      o.wr = 1'b1; o.addr = 9'(k);
    end else if (k < 9 * DEPTH) begin
      j = k - DEPTH;
      e = 1 + j / (2 * DEPTH);
      w = (j % (2 * DEPTH)) / 2;
      o.wr = (j % 2) == 1;
      o.addr = (e <= 2) ? 9'(w) : 9'(DEPTH - 1 - w);
      o.din = (e == 1 || e == 3) ? ~bg : bg;
    end else begin
      o.addr = 9'(k - 9 * DEPTH);
    end
    return o;
  endfunction

  // Op-stream monitor for the default instance; any bubble restarts the index.
  int idx_a = 0, op_err_a = 0, e0_bg_wr = 0, last_len = 0;
  always @(negedge clk) begin
    op_t e;
    if (rst || csb0) begin
      if (idx_a != 0) last_len = idx_a;
      idx_a = 0;
    end else begin
      e = exp_op(idx_a, 8'h00);
      if (idx_a >= NOPS || web0 !== !e.wr || addr0 !== e.addr || (e.wr && din0 !== e.din))
        op_err_a++;
      if (idx_a < DEPTH && !web0 && din0 === 8'h00) e0_bg_wr++;
      idx_a++;
    end
  end

  int idx_b = 0;
  logic [7:0] b_din_op0 = '0, b_din_op513 = '0;
  logic b_web_op512 = 1'b0;
  always @(negedge clk) begin
    if (csb0_b) idx_b = 0;
    else begin
      if (idx_b == 0) b_din_op0 = din0_b;
      if (idx_b == 512) b_web_op512 = web0_b;
      if (idx_b == 513) b_din_op513 = din0_b;
      idx_b++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; start is sampled on the following edge T.
  task automatic do_run(input string tag, input res_t r, input int glitch_op, output int t0);
    int n;
    res_t got;
    sb.push_back(r);
    op_err_a = 0; e0_bg_wr = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    check({tag, " busy_after_start"}, busy, 1);
    check({tag, " done_cleared"}, done, 0);
    check({tag, " err_cnt_cleared"}, err_cnt, 0);
    if (glitch_op >= 0) begin
      while (cyc < t0 + 1 + glitch_op) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 6000) begin @(negedge clk); n++; end
    check({tag, " done_seen"}, done, 1);
    check({tag, " done_latency"}, cyc - t0, 5122);
    check({tag, " busy_low_at_done"}, busy, 0);
    check({tag, " op_stream_errs"}, op_err_a, 0);
    check({tag, " op_count"}, last_len, NOPS);
    got = sb.pop_front();
    check({tag, " pass"}, pass, got.pass);
    check({tag, " err_cnt"}, err_cnt, got.err);
    if (!got.pass) begin
      check({tag, " fail_addr"}, fail_addr, got.fa);
      check({tag, " fail_elem"}, fail_elem, got.fe);
      check({tag, " fail_data"}, fail_data, got.fd);
    end
  endtask

  initial begin
    int t0, n;
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst pass", pass, 0);
    check("rst err_cnt", err_cnt, 0);
    check("rst fail_bus", {fail_addr, fail_elem, fail_data}, 0);
    check("rst pins", {csb0, web0, addr0, din0}, {1'b1, 1'b1, 17'h0});
    rst = 1'b0;
    while (cyc < 9) @(negedge clk);

    do_run("clean", '{1'b1, 8'd0, 9'd0, 3'd0, 8'd0}, -1, t0);
    check("clean start_edge", t0, 10);
    check("clean e0_bg_writes", e0_bg_wr, DEPTH);

    stuck_addr = 9'h1A5; stuck_mask = 8'h08;
    do_run("stuck", '{1'b0, 8'd3, 9'h1A5, 3'd1, 8'h08}, -1, t0);
    stuck_mask = 8'h00;

    do_run("b2b", '{1'b1, 8'd0, 9'd0, 3'd0, 8'd0}, -1, t0);

    all_ff = 1'b1;
    do_run("all_ff", '{1'b0, 8'd255, 9'd0, 3'd1, 8'hFF}, -1, t0);
    all_ff = 1'b0;

    do_run("ignored_start", '{1'b1, 8'd0, 9'd0, 3'd0, 8'd0}, 2000, t0);

    all_ff = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    while (cyc < t0 + 1 + 2600) @(negedge clk);
    check("midE3 err_before_rst", err_cnt, 255);
    #2 rst = 1'b1;
    #1;
    check("midE3 busy", busy, 0);
    check("midE3 csb0", csb0, 1);
    check("midE3 err_cnt", err_cnt, 0);
    check("midE3 done_pass", {done, pass}, 0);
    @(negedge clk);
    rst = 1'b0;
    all_ff = 1'b0;
    @(negedge clk);
    do_run("restart", '{1'b1, 8'd0, 9'd0, 3'd0, 8'd0}, -1, t0);

    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    t0 = cyc;
    n = 0;
    while (!done_b && n < 6000) begin @(negedge clk); n++; end
    check("bg5a done_latency", cyc - t0, 5122);
    check("bg5a pass", pass_b, 1);
    check("bg5a err_cnt", err_cnt_b, 0);
    check("bg5a e0_data", b_din_op0, 8'h5A);
    check("bg5a e1_first_is_read", b_web_op512, 1);
    check("bg5a e1_write_data", b_din_op513, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
